// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: round-robin owner of one shared entry/exit barrier, with lot occupancy tracking.
// Define GATE_TIMEOUT_EN to add the open-window timer and timeout_err_o pulse.
module parking_gate_arbiter #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int OPEN_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             entry_req_i,
    input  logic             entry_auth_i,
    input  logic             exit_req_i,
    input  logic             gate_clear_i,
    output logic             gate_open_o,
    output logic             grant_entry_o,
    output logic             grant_exit_o,
    output logic [CNT_W-1:0] occupancy_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             timeout_err_o
);

    typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLOSE} state_e;

    localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] OCC_ONE = CNT_W'(1);

`ifdef GATE_TIMEOUT_EN
    localparam int               TMR_W    = $clog2(OPEN_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    logic [TMR_W-1:0] timer_q;
    logic             timeout_err_q;
`endif

    state_e           state_q;
    logic             last_entry_q;
    logic             gate_open_q;
    logic             grant_entry_q;
    logic             grant_exit_q;
    logic [CNT_W-1:0] occ_q;

    logic full_w;
    logic empty_w;
    logic entry_elig;
    logic exit_elig;
    logic pick_entry;

    assign full_w     = (occ_q == CAP);
    assign empty_w    = (occ_q == '0);
    assign entry_elig = entry_req_i && entry_auth_i && !full_w;
    assign exit_elig  = exit_req_i && !empty_w;
    // On a tie the side that did not win last time is served.
    assign pick_entry = entry_elig && (!exit_elig || !last_entry_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            last_entry_q  <= 1'b0;
            gate_open_q   <= 1'b0;
            grant_entry_q <= 1'b0;
            grant_exit_q  <= 1'b0;
            occ_q         <= '0;
`ifdef GATE_TIMEOUT_EN
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
`ifdef GATE_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_entry) begin
                        state_q       <= OPEN_IN;
                        gate_open_q   <= 1'b1;
                        grant_entry_q <= 1'b1;
                        last_entry_q  <= 1'b1;
`ifdef GATE_TIMEOUT_EN
                        timer_q       <= TMR_LOAD;
`endif
                    end else if (exit_elig) begin
                        state_q       <= OPEN_OUT;
                        gate_open_q   <= 1'b1;
                        grant_exit_q  <= 1'b1;
                        last_entry_q  <= 1'b0;
`ifdef GATE_TIMEOUT_EN
                        timer_q       <= TMR_LOAD;
`endif
                    end
                end
                OPEN_IN, OPEN_OUT: begin
                    // A clear in the last open cycle beats the timer expiring.
                    if (gate_clear_i) begin
                        state_q       <= CLOSE;
                        gate_open_q   <= 1'b0;
                        grant_entry_q <= 1'b0;
                        grant_exit_q  <= 1'b0;
                        if (state_q == OPEN_IN) begin
                            if (!full_w) occ_q <= occ_q + OCC_ONE;
                        end else begin
                            if (!empty_w) occ_q <= occ_q - OCC_ONE;
                        end
                    end
`ifdef GATE_TIMEOUT_EN
                    else if (timer_q == '0) begin
                        state_q       <= CLOSE;
                        gate_open_q   <= 1'b0;
                        grant_entry_q <= 1'b0;
                        grant_exit_q  <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TMR_ONE;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gate_open_o   = gate_open_q;
    assign grant_entry_o = grant_entry_q;
    assign grant_exit_o  = grant_exit_q;
    assign occupancy_o   = occ_q;
    assign full_o        = full_w;
    assign empty_o       = empty_w;
`ifdef GATE_TIMEOUT_EN
    assign timeout_err_o = timeout_err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: table vectors, directed corner sequences and randomized traffic
// checked against a transaction-level model of the shared barrier.
module tb_parking_gate_arbiter;

    localparam int CAPACITY    = 8;
    localparam int CNT_W       = 4;
    localparam int OPEN_CYCLES = 16;
`ifdef GATE_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             entryReq;
    logic             entryAuth;
    logic             exitReq;
    logic             gateClear;
    logic             gateOpen;
    logic             grantEntry;
    logic             grantExit;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             timeoutErr;

    int checks = 0;
    int errors = 0;

    // Model state: which side holds the gate (0 none, 1 entry, 2 exit), how many cycles
    // it has been open, whether the one-cycle hold-off is pending, and the lot count.
    int mSide;
    int mOpenCount;
    bit mHoldOff;
    bit mTimeout;
    int mOcc;
    bit mLastWasEntry;

    typedef struct {
        logic er;
        logic ea;
        logic xr;
        logic clr;
        logic gate;
        logic gE;
        logic gX;
        int   occ;
        logic tmo;
    } vec_t;

    vec_t vecs [12];

    parking_gate_arbiter #(
        .CAPACITY   (CAPACITY),
        .CNT_W      (CNT_W),
        .OPEN_CYCLES(OPEN_CYCLES)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .entry_req_i  (entryReq),
        .entry_auth_i (entryAuth),
        .exit_req_i   (exitReq),
        .gate_clear_i (gateClear),
        .gate_open_o  (gateOpen),
        .grant_entry_o(grantEntry),
        .grant_exit_o (grantExit),
        .occupancy_o  (occupancy),
        .full_o       (full),
        .empty_o      (empty),
        .timeout_err_o(timeoutErr)
    );

    always #5 clk = ~clk;

    // Return the model to its power-on picture: closed, empty lot, exit counted as last winner.
    task automatic modelReset();
        mSide         = 0;
        mOpenCount    = 0;
        mHoldOff      = 1'b0;
        mTimeout      = 1'b0;
        mOcc          = 0;
        mLastWasEntry = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs that edge sampled.
    task automatic modelStep(input logic er, input logic ea, input logic xr, input logic clr);
        bit entryOk;
        bit exitOk;
        mTimeout = 1'b0;
        if (mHoldOff) begin
            mHoldOff = 1'b0;
        end else if (mSide != 0) begin
            if (clr) begin
                if (mSide == 1) mOcc = (mOcc < CAPACITY) ? mOcc + 1 : mOcc;
                else            mOcc = (mOcc > 0) ? mOcc - 1 : mOcc;
                mSide    = 0;
                mHoldOff = 1'b1;
            end else if (TIMEOUT_EN && mOpenCount == OPEN_CYCLES) begin
                mSide    = 0;
                mHoldOff = 1'b1;
                mTimeout = 1'b1;
            end else begin
                mOpenCount++;
            end
        end else begin
            entryOk = er && ea && (mOcc < CAPACITY);
            exitOk  = xr && (mOcc > 0);
            if (entryOk && exitOk) mSide = mLastWasEntry ? 2 : 1;
            else if (entryOk)      mSide = 1;
            else if (exitOk)       mSide = 2;
            if (mSide != 0) begin
                mOpenCount    = 1;
                mLastWasEntry = (mSide == 1);
            end
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Compare the whole output bundle against the model's view of the current cycle.
    task automatic checkOutput(input string name);
        logic [9:0] act;
        logic [9:0] exp;
        act = {gateOpen, grantEntry, grantExit, occupancy, full, empty, timeoutErr};
        exp = {mSide != 0, mSide == 1, mSide == 2, CNT_W'(mOcc),
               mOcc == CAPACITY, mOcc == 0, mTimeout};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (gate,gE,gX,occ,full,empty,tmo)", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, check at the next falling edge.
    task automatic stepCycle(input logic er, input logic ea, input logic xr, input logic clr);
        entryReq  = er;
        entryAuth = ea;
        exitReq   = xr;
        gateClear = clr;
        @(posedge clk);
        modelStep(er, ea, xr, clr);
        @(negedge clk);
        checkOutput("model");
    endtask

    task automatic applyStimulus(input int i);
        logic [9:0] act;
        logic [9:0] exp;
        stepCycle(vecs[i].er, vecs[i].ea, vecs[i].xr, vecs[i].clr);
        act = {gateOpen, grantEntry, grantExit, occupancy, full, empty, timeoutErr};
        exp = {vecs[i].gate, vecs[i].gE, vecs[i].gX, CNT_W'(vecs[i].occ),
               vecs[i].occ == CAPACITY, vecs[i].occ == 0, vecs[i].tmo};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL vec%0d: got %b expected %b", i, act, exp);
        end
    endtask

    // One complete transaction: a settle cycle, the grant, then the clear.
    task automatic serveEntry();
        stepCycle(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle(1'b1, 1'b1, 1'b0, 1'b0);
        stepCycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic serveExit();
        stepCycle(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle(1'b0, 1'b0, 1'b1, 1'b0);
        stepCycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int gateHigh;
        int tmoCount;

        // Vectors run straight after reset: blocked requests, a 3-cycle entry, hold-off,
        // round-robin tie-break and an exit that is ineligible because the lot is empty.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};

        reset     = 1'b1;
        entryReq  = 1'b0;
        entryAuth = 1'b0;
        exitReq   = 1'b0;
        gateClear = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("resetState");

        for (int i = 0; i < 12; i++) applyStimulus(i);

        // Open-window behaviour: expiry after exactly OPEN_CYCLES, and a clear in the last cycle.
`ifdef GATE_TIMEOUT_EN
        stepCycle(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle(1'b1, 1'b1, 1'b0, 1'b0);
        gateHigh = int'(gateOpen);
        tmoCount = 0;
        repeat (19) begin
            stepCycle(1'b0, 1'b0, 1'b0, 1'b0);
            gateHigh += int'(gateOpen);
            tmoCount += int'(timeoutErr);
        end
        checkValue("timeoutOpenCycles", gateHigh, 16);
        checkValue("timeoutPulses", tmoCount, 1);
        checkValue("timeoutOcc", int'(occupancy), 1);

        stepCycle(1'b1, 1'b1, 1'b0, 1'b0);
        tmoCount = 0;
        repeat (15) begin
            stepCycle(1'b0, 1'b0, 1'b0, 1'b0);
            tmoCount += int'(timeoutErr);
        end
        checkValue("openBeforeFinal", int'(gateOpen), 1);
        stepCycle(1'b0, 1'b0, 1'b0, 1'b1);
        tmoCount += int'(timeoutErr);
        stepCycle(1'b0, 1'b0, 1'b0, 1'b0);
        tmoCount += int'(timeoutErr);
        checkValue("finalClearTmo", tmoCount, 0);
        checkValue("finalClearOcc", int'(occupancy), 2);
`else
        stepCycle(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle(1'b1, 1'b1, 1'b0, 1'b0);
        gateHigh = 0;
        tmoCount = 0;
        repeat (40) begin
            stepCycle(1'b0, 1'b0, 1'b0, 1'b0);
            gateHigh += int'(gateOpen);
            tmoCount += int'(timeoutErr);
        end
        checkValue("holdOpenCycles", gateHigh, 40);
        checkValue("noTimeoutPulses", tmoCount, 0);
        stepCycle(1'b0, 1'b0, 1'b0, 1'b1);
        checkValue("lateClearOcc", int'(occupancy), 2);
`endif

        // Fill the lot, confirm entry is refused when full, then free one space.
        repeat (6) serveEntry();
        checkValue("fullFlag", int'(full), 1);
        stepCycle(1'b0, 1'b0, 1'b0, 1'b0);
        gateHigh = 0;
        repeat (3) begin
            stepCycle(1'b1, 1'b1, 1'b0, 1'b0);
            gateHigh += int'(gateOpen);
        end
        checkValue("fullNoGrant", gateHigh, 0);
        serveExit();
        checkValue("afterExitOcc", int'(occupancy), 7);
        checkValue("afterExitFull", int'(full), 0);
        serveEntry();
        checkValue("refillOcc", int'(occupancy), 8);
        repeat (3) serveExit();

        // Asynchronous reset in the middle of an exit transaction.
        stepCycle(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle(1'b0, 1'b0, 1'b1, 1'b0);
        checkValue("preResetGrantExit", int'(grantExit), 1);
        checkValue("preResetOcc", int'(occupancy), 5);
        #1 reset = 1'b1;
        #1;
        checkValue("asyncGate", int'(gateOpen), 0);
        checkValue("asyncGrantExit", int'(grantExit), 0);
        checkValue("asyncOcc", int'(occupancy), 0);
        checkValue("asyncEmpty", int'(empty), 1);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkOutput("postReset");
        stepCycle(1'b1, 1'b1, 1'b1, 1'b0);
        checkValue("resumeGrantEntry", int'(grantEntry), 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            stepCycle($urandom_range(99) < 60, $urandom_range(99) < 70,
                      $urandom_range(99) < 50, $urandom_range(99) < 12);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Arbitration and sequencing controller for a single shared parking barrier serving both the entrance and exit lanes. It grants the gate to one requester at a time with round-robin fairness and holds it open until the vehicle clears or a timeout expires. It also keeps the lot occupancy count and blocks entry when the lot is full. It sits between the lane sensors / password checker and the barrier actuator and display logic.

## Interface
- CAPACITY, 8: maximum number of parked vehicles; must be 1..(2^CNT_W − 1).
- CNT_W, 4: width of the occupancy counter.
- OPEN_CYCLES, 16: maximum gate-open duration in clk cycles; must be ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- entry_req  in  1  level; a vehicle is waiting at the entrance.
- entry_auth  in  1  level; the password checker has accepted the waiting vehicle.
- exit_req  in  1  level; a vehicle is waiting at the exit.
- gate_clear  in  1  one-cycle pulse; the vehicle has passed the barrier.
- gate_open  out  1  barrier open command.
- grant_entry  out  1  gate currently serves the entrance.
- grant_exit  out  1  gate currently serves the exit.
- occupancy  out  CNT_W  current number of parked vehicles.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- timeout_err  out  1  one-cycle pulse; the open window expired without gate_clear.

## Operation
- States: IDLE, OPEN_IN, OPEN_OUT, CLOSE.
- Eligibility:
  - Entry is eligible when entry_req && entry_auth && !full.
  - Exit is eligible when exit_req && !empty.
- IDLE:
  - Only entry eligible → OPEN_IN.
  - Only exit eligible → OPEN_OUT.
  - Both eligible → serve the side opposite last_grant.
  - On each grant, last_grant updates and the timer loads OPEN_CYCLES−1.
- OPEN_IN / OPEN_OUT:
  - gate_open = 1, with the matching grant_* = 1.
  - Requests are ignored while open: dropping entry_req/exit_req does not abort the transaction.
- gate_clear while open:
  - OPEN_IN → occupancy +1; OPEN_OUT → occupancy −1.
  - Next state CLOSE.
- Timer reaching 0 without gate_clear:
  - timeout_err pulses for one cycle.
  - No occupancy change; next state CLOSE.
- gate_clear and timer expiry in the same cycle: gate_clear wins, occupancy updates, and no timeout_err.
- CLOSE: all outputs deasserted for exactly one cycle (barrier hold-off), then IDLE.
- gate_clear outside OPEN_* is ignored.
- Occupancy saturates at 0 and CAPACITY as a guard; eligibility rules already prevent overflow and underflow.
- grant_entry and grant_exit are never high together. gate_open == grant_entry | grant_exit.

## Timing
- All outputs are registered; full and empty are decoded from the registered occupancy.
- Reset values:
  - gate_open = 0, grant_entry = 0, grant_exit = 0, timeout_err = 0.
  - occupancy = 0, empty = 1, full = 0.
  - State IDLE; last_grant = exit, so entry wins the first tie.
- Grant latency: eligibility sampled at edge N → gate_open/grant_* high after edge N.
- gate_clear sampled high at edge M:
  - gate_open drops after M.
  - occupancy/full/empty update after M.
  - State is IDLE after M+1.
  - Earliest next grant is after M+2.
- Window length: gate_open stays high at most OPEN_CYCLES cycles. timeout_err is high in the cycle following the last open cycle, coincident with CLOSE.
- Reset asserted mid-transaction: gate closes immediately (asynchronously) and occupancy clears to 0.

## Configuration
- GATE_TIMEOUT_EN defined:
  - Open-window timer and timeout_err are implemented as described above.
- GATE_TIMEOUT_EN undefined:
  - No timer; OPEN_* is held until gate_clear.
  - timeout_err is tied to 0.
  - OPEN_CYCLES is unused.

## Test plan
- Reset, then entry_req=1, entry_auth=1, gate_clear 3 cycles after grant → grant_entry for 3 cycles, occupancy 0→1, empty 1→0, gate low for 1 cycle, then IDLE.
- entry_req, entry_auth and exit_req held continuously with occupancy=2, one gate_clear per transaction → grants alternate entry, exit, entry, …; occupancy alternates 3, 2, 3; grants never overlap.
- Fill to CAPACITY=8, then entry_req=1, entry_auth=1 → full=1 and no grant; exit_req then served, occupancy 7, full=0, and the next entry is granted.
- GATE_TIMEOUT_EN defined, OPEN_CYCLES=16, entry granted with no gate_clear → gate_open high for exactly 16 cycles, one timeout_err pulse, occupancy unchanged. Repeat with gate_clear in the final open cycle → occupancy +1 and no timeout_err.
- With empty=1, exit_req=1 → no grant. With entry_req=1 and entry_auth=0 → no grant.
- reset pulsed in OPEN_OUT with occupancy=5 → gate_open, grant_exit and occupancy go to 0 and empty goes to 1 without waiting for a clock edge; normal arbitration resumes after release.
